// File: rtl/seqpu_pkg.sv
// Shared types and default sizing for the bit-serial datapath.
package seqpu_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/serial_shifter.sv
// Parallel-load right-shift register: serial-in at MSB, serial-out at q[0].
// Single-cycle load/shift; load has priority over shift.
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_regfile.sv
// Register file feeding a bit-serial ALU: streams two operands LSB-first over WIDTH
// cycles, reassembles the serial result and writes it back; no start queueing.
module serial_regfile
  import seqpu_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  output logic             busy,
  output logic             done,
  output logic             alu_en,
  output logic             a,
  output logic             b,
  input  logic             y,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [CW-1:0]    bitcnt;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] sa_q, sb_q, res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             load, shift, wb;
  logic             unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_en  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    wb      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        alu_en = 1'b1;
        shift  = 1'b1;
        if (bitcnt == LAST_BIT) begin
          wb      = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      rd_q   <= '0;
    end else if (load) begin
      bitcnt <= '0;
      rd_q   <= rd;
    end else if (shift) begin
      bitcnt <= bitcnt + CW'(1);
    end
  end

  serial_shifter #(.WIDTH(WIDTH)) u_sa (
    .clk(clk), .rst(rst), .load(load), .load_val(regs[ra]),
    .shift(shift), .sin(1'b0), .q(sa_q)
  );

  serial_shifter #(.WIDTH(WIDTH)) u_sb (
    .clk(clk), .rst(rst), .load(load), .load_val(regs[rb]),
    .shift(shift), .sin(1'b0), .q(sb_q)
  );

  serial_shifter #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .rst(rst), .load(load), .load_val('0),
    .shift(shift), .sin(y), .q(res_q)
  );

  assign a       = sa_q[0];
  assign b       = sb_q[0];
  assign res_nxt = {y, res_q[WIDTH-1:1]};

  // Writeback is the later assignment, so it wins over a host write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
      if (wb) begin
        regs[rd_q] <= res_nxt;
      end
    end
  end

  assign rd_data = regs[rd_addr];

  assign unused_bits = ^{sa_q[WIDTH-1:1], sb_q[WIDTH-1:1], res_q[0]};

endmodule

// File: tb/tb_serial_regfile.sv
// Scoreboard bench for serial_regfile with an attached bit-serial ALU model.
module tb_serial_regfile;

  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, start, wr_en;
  logic [1:0] ra, rb, rd, wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, alu_en, a, b, y;

  logic [1:0] stim_addr = '0, mon_addr = '0;
  logic       mon_sel = 1'b0;
  assign rd_addr = mon_sel ? mon_addr : stim_addr;

  serial_regfile #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rb(rb), .rd(rd),
    .busy(busy), .done(done), .alu_en(alu_en), .a(a), .b(b), .y(y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor; carry/borrow cleared while alu_en is low.
  int   opcode = 0;
  logic carry = 1'b0;
  always_comb begin
    case (opcode)
      0, 1:    y = a ^ b ^ carry;
      2:       y = a & b;
      3:       y = a | b;
      default: y = a ^ b;
    endcase
  end
  always @(posedge clk) begin
    if (!alu_en)          carry <= 1'b0;
    else if (opcode == 0) carry <= (a & b) | (carry & (a ^ b));
    else if (opcode == 1) carry <= (~a & b) | (~(a ^ b) & carry);
    else                  carry <= 1'b0;
  end

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    int         e0;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] calc(input int op, input logic [7:0] x, input logic [7:0] z);
    case (op)
      0:       return x + z;
      1:       return x - z;
      2:       return x & z;
      3:       return x | z;
      default: return x ^ z;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc - e.e0), 32'(W));
          mon_addr = e.rd;
          mon_sel  = 1'b1;
          #1;
          chk("wb_value", 32'(rd_data), 32'(e.val));
          mon_sel  = 1'b0;
        end
      end
    end
  end

  logic [7:0] m_regs [N];
  logic [1:0] pend_rd;
  logic [7:0] pend_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] wa, input logic [7:0] wd);
    wr_en = 1'b1; wr_addr = wa; wr_data = wd;
    tick();
    wr_en = 1'b0;
    m_regs[wa] = wd;
  endtask

  task automatic issue_op(input int op, input logic [1:0] xa, input logic [1:0] xb,
                          input logic [1:0] xd, input bit do_wr, input logic [7:0] wd);
    exp_t e;
    opcode = op; ra = xa; rb = xb; rd = xd; start = 1'b1;
    e.rd = xd; e.val = calc(op, m_regs[xa], m_regs[xb]); e.e0 = cyc + 1;
    sbq.push_back(e);
    pend_rd = xd; pend_val = e.val;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = xa; wr_data = wd;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (do_wr) m_regs[xa] = wd;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("op_timeout", 32'(busy), 32'd0);
    m_regs[pend_rd] = pend_val;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      stim_addr = 2'(i);
      #1;
      chk(tag, 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    ra = '0; rb = '0; rd = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_alu_en", 32'(alu_en), 32'd0);
    chk("reset_ab", 32'({a, b}), 32'd0);
    check_all("reset_regs");

    // Add 0x5A + 0x3C -> 0x96
    host_write(2'd0, 8'h5A);
    host_write(2'd1, 8'h3C);
    issue_op(0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    wait_done();
    check_all("add_regs");

    // Subtract wrap 0x10 - 0x20 -> 0xF0, busy for WIDTH+1 cycles
    host_write(2'd0, 8'h10);
    host_write(2'd1, 8'h20);
    issue_op(1, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    n = 0;
    while (busy && n < 60) begin
      n++;
      tick();
    end
    chk("busy_cycles", 32'(n), 32'(W + 1));
    wait_done();
    check_all("sub_regs");

    // In-place xor, then host write colliding with writeback
    host_write(2'd3, 8'hFF);
    issue_op(4, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);
    wait_done();
    check_all("inplace_regs");
    host_write(2'd3, 8'hFF);
    issue_op(4, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);
    repeat (W - 1) tick();
    host_write(2'd3, 8'h77);
    wait_done();
    check_all("collision_regs");

    // Start during SHIFT ignored; source overwrite mid-op doesn't disturb operands
    host_write(2'd0, 8'h21);
    host_write(2'd1, 8'h13);
    issue_op(0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    repeat (2) tick();
    ra = 2'd2; rb = 2'd2; rd = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    host_write(2'd0, 8'h00);
    wait_done();
    repeat (W + 4) tick();
    check_all("isolation_regs");

    // Reset in cycle 4 of a carry-heavy add
    host_write(2'd0, 8'hFF);
    host_write(2'd1, 8'h01);
    issue_op(0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sbq.pop_back());
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    chk("rst_mid_alu_en", 32'(alu_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    check_all("rst_mid_regs");
    host_write(2'd0, 8'h01);
    host_write(2'd1, 8'h01);
    issue_op(0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    wait_done();
    check_all("post_rst_add");

    // Randomized operations with same-cycle and mid-op host writes
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 2)) host_write(2'($urandom_range(0, N - 1)), 8'($urandom));
      issue_op(int'($urandom_range(0, 4)), 2'($urandom_range(0, N - 1)),
               2'($urandom_range(0, N - 1)), 2'($urandom_range(0, N - 1)),
               ($urandom_range(0, 3) == 0), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, W - 2)) tick();
        host_write(2'($urandom_range(0, N - 1)), 8'($urandom));
      end
      wait_done();
    end
    check_all("final_regs");
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_regfile.md
# serial_regfile

Operand/result stage for the bit-serial ALU. Holds a small register file and, on `start`, streams two source registers LSB-first into the ALU's `a`/`b` inputs over `WIDTH` cycles. It assembles the ALU's serial `y` output back into a word and writes that word to a destination register. A host port gives parallel register read/write access, so the block is the word-level face of the serial datapath.

## Interface
Parameters:
- `WIDTH`, 8: register and operand width; equals the number of serial bit-cycles.
- `NREGS`, 4: number of registers; address width is `AW = $clog2(NREGS)`.

Ports:
- `clk`, in, 1: clock, rising edge. One clock domain only.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request one serial operation; sampled only in IDLE.
- `ra`, in, AW: source A register index; sampled with `start`.
- `rb`, in, AW: source B register index; sampled with `start`.
- `rd`, in, AW: destination register index; sampled with `start`.
- `busy`, out, 1: operation in progress; high in SHIFT and DONE.
- `done`, out, 1: one-cycle pulse, high for the single DONE cycle.
- `alu_en`, out, 1: to the ALU's reset input. High only in SHIFT. Low clears the ALU's carry/borrow state.
- `a`, out, 1: serial operand A bit to the ALU; `sa[0]`.
- `b`, out, 1: serial operand B bit to the ALU; `sb[0]`.
- `y`, in, 1: serial result bit from the ALU, combinational from the current `a`/`b` plus the ALU's internal state.
- `wr_en`, in, 1: host register write.
- `wr_addr`, in, AW: host write index.
- `wr_data`, in, WIDTH: host write data.
- `rd_addr`, in, AW: host read index.
- `rd_data`, out, WIDTH: `regs[rd_addr]`, combinational.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `start=1` loads `sa <= regs[ra]` and `sb <= regs[rb]`, latches `rd` into `rd_q`, clears `bitcnt` and `res`, and moves to SHIFT.
  - `start=0` stays in IDLE.
- **SHIFT**
  - Each cycle: `res <= {y, res[WIDTH-1:1]}`, `sa <= sa>>1`, `sb <= sb>>1`, `bitcnt++`.
  - On the cycle with `bitcnt == WIDTH-1`: write `regs[rd_q] <= {y, res[WIDTH-1:1]}` and go to DONE.
- **DONE**: `done=1` for one cycle, then return to IDLE.
- `start` in SHIFT or DONE is ignored; there is no queueing.
- Host writes are accepted in every state. Operands are already latched, so writes during SHIFT never disturb an in-flight operation.
- Collisions:
  - Host write and result writeback to the same register on the same edge: the writeback wins.
  - `start` and `wr_en` in the same IDLE cycle to a source register: the operand gets the old (pre-write) value.
  - `rd` equal to `ra` or `rb` is legal; the result overwrites the source after streaming.
- Arithmetic is modulo 2^WIDTH. Any carry out of the MSB is discarded; this block has no flags.

## Timing
- `start` is sampled at edge E0.
- SHIFT runs during cycles 1..WIDTH, with `y` captured at edges E1..E_WIDTH.
- Writeback happens at E_WIDTH. DONE is cycle WIDTH+1, so `done` is high after E_WIDTH. The next `start` is accepted in cycle WIDTH+2.
- Back-to-back throughput is one operation per WIDTH+2 cycles.
- `rd_data` reflects the writeback in the DONE cycle.
- `alu_en` rises in cycle 1 and falls after E_WIDTH. The ALU therefore sees exactly WIDTH enabled cycles, with its state cleared beforehand.
- Reset values: state=IDLE, `busy=0`, `done=0`, `alu_en=0`, `a=0`, `b=0`, all `regs=0`, `bitcnt=0`.
- Reset mid-operation: return to IDLE next cycle with no writeback and no `done` pulse. Reset has priority over `start` and `wr_en`.

## Structure
- Shared package (`seqpu_pkg`): state enum (IDLE/SHIFT/DONE), default `WIDTH` and `NREGS` constants.
- `bitcnt` is `$clog2(WIDTH)+1` bits wide.
- One sub-module is natural: `serial_shifter`, a parallel-load right-shift register with serial-out LSB and serial-in MSB. Instantiate it for `sa`, `sb` and `res`.
- The register file is inline.

## Test plan
Each scenario uses the bit-serial ALU attached.
- Add: write `r0=0x5A`, `r1=0x3C`, opcode 0, `start` with ra=0, rb=1, rd=2 -> `done` at cycle 9 and `rd_data(r2)=0x96`.
- Subtract wrap: `r0=0x10`, `r1=0x20`, opcode 1 -> `r2=0xF0`. Also check that `busy` is high for exactly 9 cycles.
- In-place and collision: `r3=0xFF`, opcode 4, ra=rb=rd=3 -> `r3=0x00`. A host write `r3=0x77` at the writeback edge -> `r3=0x00`, because the writeback wins.
- Ignored start and isolation: `start` pulsed during SHIFT -> no second operation. A host write `r0=0x00` mid-SHIFT -> the result still uses the original `r0`.
- Reset mid-op: `rst` in cycle 4 -> all registers 0, no `done`, `alu_en=0`. A fresh add of `0x01+0x01` afterwards -> `0x02`, showing the ALU carry state was cleared.
